// File: rtl/rvc_asap_pkg.sv
// Shared types for the rvc_asap memory-side blocks: arbiter state encoding
// and requester indices (M0 = core LSU, M1 = DMA loader).
package rvc_asap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_M0 = 2'd1,
    ST_OWN_M1 = 2'd2
  } t_arb_state;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  function automatic t_arb_state own_state_of(input logic idx);
    return idx ? ST_OWN_M1 : ST_OWN_M0;
  endfunction

endpackage

// File: rtl/rvc_asap_5pl_arb_sel.sv
// Pure grant selection for the two-master memory arbiter, plus next-state terms.
// RVC_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed M0 priority in IDLE.
module rvc_asap_5pl_arb_sel
  import rvc_asap_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 3
) (
  input  t_arb_state       i_state,
  input  logic             i_last_gnt,
  input  logic [1:0]       i_req,
  input  logic [1:0]       i_lock,
  input  logic [CNT_W-1:0] i_burst_cnt,
  output logic [1:0]       o_gnt,
  output t_arb_state       o_nxt_state,
  output logic [CNT_W-1:0] o_nxt_cnt,
  output logic             o_nxt_last
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);

  logic w_at_limit;
  logic w_any;
  logic w_win;
  logic w_idle_pick;

  assign w_at_limit = (i_burst_cnt == CNT_LIMIT);
  assign w_any      = |i_req;

`ifdef RVC_ARB_ROUND_ROBIN_EN
  assign w_idle_pick = ~i_last_gnt;
`else
  assign w_idle_pick = ARB_M0;
`endif

  // The owner keeps priority unless its burst is exhausted and the other side waits.
  always_comb begin
    w_win = ARB_M0;
    case (i_state)
      ST_OWN_M0: w_win = (i_req[0] && !(w_at_limit && i_req[1])) ? ARB_M0 : ARB_M1;
      ST_OWN_M1: w_win = (i_req[1] && !(w_at_limit && i_req[0])) ? ARB_M1 : ARB_M0;
      default:   w_win = (&i_req) ? w_idle_pick : (i_req[1] ? ARB_M1 : ARB_M0);
    endcase
  end

  assign o_gnt      = w_any ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign o_nxt_last = w_any ? w_win : i_last_gnt;

  always_comb begin
    o_nxt_state = ST_IDLE;
    o_nxt_cnt   = '0;
    if (w_any && i_lock[w_win]) begin
      o_nxt_state = own_state_of(w_win);
      if ((i_state == own_state_of(w_win)) && !w_at_limit)
        o_nxt_cnt = i_burst_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rvc_asap_5pl_mem_arb.sv
// Two-master (core LSU / DMA loader) single-port memory arbiter with burst locking.
// Define RVC_ARB_ROUND_ROBIN_EN for round-robin IDLE contention; default is fixed M0 priority.
module rvc_asap_5pl_mem_arb
  import rvc_asap_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                Clock,
  input  logic                Rst_N,
  input  logic                M0Req,
  input  logic                M1Req,
  input  logic                M0Lock,
  input  logic                M1Lock,
  input  logic [ADDR_W-1:0]   M0Addr,
  input  logic [ADDR_W-1:0]   M1Addr,
  input  logic                M0WrEn,
  input  logic                M1WrEn,
  input  logic [DATA_W/8-1:0] M0ByteEn,
  input  logic [DATA_W/8-1:0] M1ByteEn,
  input  logic [DATA_W-1:0]   M0WrData,
  input  logic [DATA_W-1:0]   M1WrData,
  output logic                M0Gnt,
  output logic                M1Gnt,
  output logic                M0RdValid,
  output logic                M1RdValid,
  output logic [DATA_W-1:0]   M0RdData,
  output logic [DATA_W-1:0]   M1RdData,
  output logic                MemEn,
  output logic                MemWrEn,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W/8-1:0] MemByteEn,
  output logic [DATA_W-1:0]   MemWrData,
  input  logic [DATA_W-1:0]   MemRdData
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  t_arb_state       r_state;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_last_gnt;
  logic [1:0]       r_rd_vld;

  logic [1:0]       w_sel_gnt;
  logic [1:0]       w_gnt;
  logic             w_any_gnt;
  logic [1:0]       w_rd_issue;
  t_arb_state       w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic             w_nxt_last;

  rvc_asap_5pl_arb_sel #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_sel (
    .i_state     (r_state),
    .i_last_gnt  (r_last_gnt),
    .i_req       ({M1Req, M0Req}),
    .i_lock      ({M1Lock, M0Lock}),
    .i_burst_cnt (r_burst_cnt),
    .o_gnt       (w_sel_gnt),
    .o_nxt_state (w_nxt_state),
    .o_nxt_cnt   (w_nxt_cnt),
    .o_nxt_last  (w_nxt_last)
  );

  // Grants are combinational, so they must be forced low while reset is held.
  assign w_gnt     = w_sel_gnt & {2{Rst_N}};
  assign w_any_gnt = |w_gnt;
  assign M0Gnt     = w_gnt[0];
  assign M1Gnt     = w_gnt[1];

  assign MemEn     = w_any_gnt;
  assign MemWrEn   = w_any_gnt & (w_gnt[1] ? M1WrEn : M0WrEn);
  assign MemAddr   = w_any_gnt ? (w_gnt[1] ? M1Addr   : M0Addr)   : '0;
  assign MemByteEn = w_any_gnt ? (w_gnt[1] ? M1ByteEn : M0ByteEn) : '0;
  assign MemWrData = w_any_gnt ? (w_gnt[1] ? M1WrData : M0WrData) : '0;

  assign w_rd_issue = w_gnt & ~{M1WrEn, M0WrEn};

  always_ff @(posedge Clock or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
      r_last_gnt  <= ARB_M1;
      r_rd_vld    <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_burst_cnt <= w_nxt_cnt;
      r_last_gnt  <= w_nxt_last;
      r_rd_vld    <= w_rd_issue;
    end
  end

  // Memory returns read data one cycle after the strobe; steer it to the issuer.
  assign M0RdValid = r_rd_vld[0];
  assign M1RdValid = r_rd_vld[1];
  assign M0RdData  = r_rd_vld[0] ? MemRdData : '0;
  assign M1RdData  = r_rd_vld[1] ? MemRdData : '0;

endmodule

// File: tb/tb_rvc_asap_5pl_mem_arb.sv
// Self-checking bench for rvc_asap_5pl_mem_arb: directed scenarios then random traffic
// against a transaction-level model (owner / run-length / last-grant bookkeeping).
module tb_rvc_asap_5pl_mem_arb;
  import rvc_asap_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MB = 8;

  logic          Clock = 1'b0;
  logic          Rst_N;
  logic          req  [2];
  logic          lock [2];
  logic          wr   [2];
  logic [AW-1:0] addr [2];
  logic [BW-1:0] be   [2];
  logic [DW-1:0] wd   [2];
  logic [DW-1:0] mem_rd;

  logic          gnt0, gnt1, rdv0, rdv1;
  logic [DW-1:0] rdd0, rdd1;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wd;

  int total = 0;
  int bad   = 0;

  int         m_owner;
  int         m_run;
  int         m_last;
  logic [1:0] m_pend;
  logic [DW-1:0] zero_d = '0;

  always #5 Clock = ~Clock;

  rvc_asap_5pl_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .Clock(Clock), .Rst_N(Rst_N),
    .M0Req(req[0]), .M1Req(req[1]), .M0Lock(lock[0]), .M1Lock(lock[1]),
    .M0Addr(addr[0]), .M1Addr(addr[1]), .M0WrEn(wr[0]), .M1WrEn(wr[1]),
    .M0ByteEn(be[0]), .M1ByteEn(be[1]), .M0WrData(wd[0]), .M1WrData(wd[1]),
    .M0Gnt(gnt0), .M1Gnt(gnt1), .M0RdValid(rdv0), .M1RdValid(rdv1),
    .M0RdData(rdd0), .M1RdData(rdd1),
    .MemEn(mem_en), .MemWrEn(mem_wr), .MemAddr(mem_addr), .MemByteEn(mem_be),
    .MemWrData(mem_wd), .MemRdData(mem_rd)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_last  = 1;
    m_pend  = 2'b00;
  endtask

  // Who should win this cycle, from the arbitration rules alone.
  function automatic int pick();
    if (!req[0] && !req[1]) return -1;
    if (m_owner >= 0) begin
      int o = m_owner;
      int x = 1 - m_owner;
      if (req[o] && !(((m_run % MB) == 0) && req[x])) return o;
      return x;
    end
    if (req[0] && req[1]) begin
`ifdef RVC_ARB_ROUND_ROBIN_EN
      return 1 - m_last;
`else
      return 0;
`endif
    end
    return req[0] ? 0 : 1;
  endfunction

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; lock[k] = 1'b0; wr[k] = 1'b0;
      addr[k] = '0; be[k] = '0; wd[k] = '0;
    end
  endtask

  // Called just after a falling edge with inputs applied; returns after the next falling edge.
  task automatic tick();
    int            g;
    logic [1:0]    eg;
    logic [69:0]   emem;
    t_arb_state    est;
    int            ecnt;
    #1;
    g    = Rst_N ? pick() : -1;
    eg   = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    emem = (g >= 0) ? {1'b1, wr[g], addr[g], be[g], wd[g]} : '0;
    est  = (m_owner == 0) ? ST_OWN_M0 : (m_owner == 1) ? ST_OWN_M1 : ST_IDLE;
    ecnt = (m_owner >= 0) ? ((m_run - 1) % MB) : 0;
    chk("gnt", {gnt1, gnt0}, eg);
    chk("mem", {mem_en, mem_wr, mem_addr, mem_be, mem_wd}, emem);
    chk("rdvalid", {rdv1, rdv0}, m_pend);
    chk("rddata", {rdd1, rdd0}, {(m_pend[1] ? mem_rd : zero_d), (m_pend[0] ? mem_rd : zero_d)});
    chk("state", dut.r_state, est);
    chk("burstcnt", dut.r_burst_cnt, ecnt);
    chk("lastgnt", dut.r_last_gnt, m_last);
    @(posedge Clock);
    if (Rst_N) begin
      m_pend = 2'b00;
      if (g >= 0) begin
        m_pend[g] = !wr[g];
        m_last    = g;
        if (lock[g]) begin
          if (m_owner == g) m_run++;
          else begin m_owner = g; m_run = 1; end
        end else begin
          m_owner = -1; m_run = 0;
        end
      end else begin
        m_owner = -1; m_run = 0;
      end
    end
    @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [1:0] exp20 [4];
    int         cnt22;
    Rst_N  = 1'b1;
    idle_inputs();
    mem_rd = 32'hA5A5_A5A5;
    model_reset();
    #2 Rst_N = 1'b0;

    // Reset: requests high must still produce no grant and no Mem activity.
    req[0] = 1'b1; req[1] = 1'b1; lock[0] = 1'b1;
    @(negedge Clock);
    tick();
    tick();
    Rst_N = 1'b1;
    idle_inputs();
    tick();

    // Lone M0 read with one-cycle data return.
    req[0] = 1'b1; addr[0] = 32'h1000; be[0] = 4'hF;
    #1 chk("r19_m0gnt", gnt0, 1'b1);
    tick();
    idle_inputs();
    mem_rd = 32'hDEAD_BEEF;
    #1 chk("r19_rdvalid", {rdv1, rdv0}, 2'b01);
    chk("r19_rddata", rdd0, 32'hDEAD_BEEF);
    tick();

    // Lone M1 write: memory sees a write, no read response follows.
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h1004; be[1] = 4'h3; wd[1] = 32'h1234_5678;
    #1 chk("r24_mem", {mem_en, mem_wr, mem_addr, mem_be, mem_wd},
           {1'b1, 1'b1, 32'h1004, 4'h3, 32'h1234_5678});
    tick();
    idle_inputs();
    #1 chk("r24_nordv", {rdv1, rdv0}, 2'b00);
    tick();

    // Unlocked contention for four cycles.
`ifdef RVC_ARB_ROUND_ROBIN_EN
    exp20 = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp20 = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    req[0] = 1'b1; req[1] = 1'b1; addr[0] = 32'h20; addr[1] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      #1 chk("r20_seq", {gnt1, gnt0}, exp20[i]);
      tick();
    end
    idle_inputs();
    tick();

    // M1 locked burst while M0 waits: eight M1 grants, then M0.
    req[1] = 1'b1; lock[1] = 1'b1; addr[1] = 32'h80;
    for (int i = 0; i < 9; i++) begin
      if (i >= 1) req[0] = 1'b1;
      #1 chk("r21_burst", {gnt1, gnt0}, (i < 8) ? 2'b10 : 2'b01);
      tick();
    end
    idle_inputs();
    tick();

    // M0 locked burst with M1 idle: owner keeps every grant, counter wraps.
    req[0] = 1'b1; lock[0] = 1'b1;
    cnt22 = 0;
    for (int i = 0; i < 20; i++) begin
      #1 if (gnt0 === 1'b1) cnt22++;
      tick();
    end
    chk("r22_count", cnt22, 20);
    idle_inputs();
    tick();

    // Reset while M1 owns the bus with a read in flight.
    req[1] = 1'b1; lock[1] = 1'b1; addr[1] = 32'hC0;
    tick();
    idle_inputs();
    Rst_N = 1'b0;
    model_reset();
    #1 chk("r23_rdv", {rdv1, rdv0}, 2'b00);
    chk("r23_state", dut.r_state, ST_IDLE);
    tick();
    Rst_N = 1'b1;
    req[0] = 1'b1; req[1] = 1'b1;
    #1 chk("r23_m0wins", {gnt1, gnt0}, 2'b01);
    tick();
    idle_inputs();
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        req[k]  = ($urandom_range(0, 3) != 0);
        lock[k] = ($urandom_range(0, 2) != 0);
        wr[k]   = $urandom_range(0, 1) == 1;
        addr[k] = $urandom;
        be[k]   = BW'($urandom);
        wd[k]   = $urandom;
      end
      mem_rd = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
